// File: rtl/hop_sel_kernel.sv
// hop_sel_kernel
// Multi-cycle hop selection engine. One request turns the captured control
// words into the RF channel for the next slot: add/XOR, a 7-stage PERM5
// butterfly (one stage per cycle), a mod-79 reduction by three conditional
// subtracts, and the register-bank mapping (even channels first, then odd).
//
// Optional adapted hopping is enabled by defining HOPKERNEL_AFH_EN. When it
// is defined, an unused basic channel is remapped: s2 mod N, then a walk of
// the used-channel map in mapping order to find the k'-th used channel.
// When it is undefined, the AFH inputs are ignored, chan_remapped and
// hop_err stay 0, and every request takes the basic path.
//
// Ports
//   clk_6M, rstz          6 MHz clock, asynchronous active-low reset
//   hop_start_p           one-cycle request; all inputs sampled on that edge
//   X Y1 Y2 A B C D E F   control words from the control-word generator
//   Fprime                AFH adder word
//   regi_AFH_mode/N/map   AFH enable, used-channel count, used-channel map
//   rf_chan               selected channel, held until the next good hop
//   hop_busy              sample edge .. done edge
//   hop_done_p            one-cycle completion pulse
//   chan_remapped         last result came from the AFH table
//   hop_err               one-cycle pulse with hop_done_p on a failed AFH hop
//
// Handshake: a request is taken only when hop_busy is low; hop_start_p
// while busy is dropped. hop_done_p marks the single cycle in which the new
// rf_chan/chan_remapped/hop_err are first valid; there is no back-pressure.
// The FSM state is held in state_q for hierarchical observation.
module hop_sel_kernel (
  input  logic        clk_6M,
  input  logic        rstz,
  input  logic        hop_start_p,
  input  logic [4:0]  X,
  input  logic        Y1,
  input  logic [5:0]  Y2,
  input  logic [4:0]  A,
  input  logic [3:0]  B,
  input  logic [4:0]  C,
  input  logic [8:0]  D,
  input  logic [6:0]  E,
  input  logic [6:0]  F,
  input  logic [6:0]  Fprime,
  input  logic        regi_AFH_mode,
  input  logic [6:0]  regi_AFH_N,
  input  logic [78:0] regi_AFH_map,
  output logic [6:0]  rf_chan,
  output logic        hop_busy,
  output logic        hop_done_p,
  output logic        chan_remapped,
  output logic        hop_err
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_ADD  = 4'd1;
  localparam logic [3:0] S_PERM = 4'd2;
  localparam logic [3:0] S_SUM  = 4'd3;
  localparam logic [3:0] S_MOD  = 4'd4;
  localparam logic [3:0] S_CHK  = 4'd5;
  localparam logic [3:0] S_MODN = 4'd6;
  localparam logic [3:0] S_SCAN = 4'd7;
  localparam logic [3:0] S_MAP  = 4'd8;

  // Bank mapping: index 0..39 -> even channels, 40..78 -> odd channels.
  function automatic logic [6:0] idx_to_chan(input logic [6:0] k);
    logic [6:0] km;
    km = k - 7'd40;
    if (k < 7'd40) idx_to_chan = {k[5:0], 1'b0};
    else           idx_to_chan = {km[5:0], 1'b1};
  endfunction

  // One butterfly stage: two disjoint bit pairs, each swapped when its
  // control bit is set. hi is the higher-numbered P bit of the stage.
  function automatic logic [4:0] perm_stage(input logic [4:0] z, input logic [2:0] st,
                                            input logic hi, input logic lo);
    logic [2:0] i0, j0, i1, j1;
    logic [4:0] r;
    case (st)
      3'd0:    begin i0 = 3'd1; j0 = 3'd2; i1 = 3'd0; j1 = 3'd3; end
      3'd1:    begin i0 = 3'd1; j0 = 3'd3; i1 = 3'd2; j1 = 3'd4; end
      3'd2:    begin i0 = 3'd0; j0 = 3'd3; i1 = 3'd1; j1 = 3'd4; end
      3'd3:    begin i0 = 3'd3; j0 = 3'd4; i1 = 3'd0; j1 = 3'd2; end
      3'd4:    begin i0 = 3'd1; j0 = 3'd3; i1 = 3'd0; j1 = 3'd4; end
      3'd5:    begin i0 = 3'd3; j0 = 3'd4; i1 = 3'd1; j1 = 3'd2; end
      default: begin i0 = 3'd2; j0 = 3'd3; i1 = 3'd0; j1 = 3'd1; end
    endcase
    r = z;
    if (hi) begin r[i0] = z[j0]; r[j0] = z[i0]; end
    if (lo) begin r[i1] = z[j1]; r[j1] = z[i1]; end
    perm_stage = r;
  endfunction

  logic [3:0]  state_q, state_d;
  logic [4:0]  x_q, x_d, a_q, a_d, z_q, z_d;
  logic [3:0]  b_q, b_d;
  logic [5:0]  y2_q, y2_d;
  logic [6:0]  e_q, e_d, f_q, f_d;
  logic [13:0] p_q, p_d;        // PERM controls; the active pair sits in [13:12]
  logic [8:0]  s_q, s_d;
  logic [6:0]  cnt_q, cnt_d;    // PERM stage / MOD step / SCAN index
  logic [6:0]  rf_chan_q, rf_chan_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [4:0]  zsum;

`ifdef HOPKERNEL_AFH_EN
  logic [6:0]  fp_q, fp_d, n_q, n_d, used_q, used_d, found_q, found_d;
  logic        mode_q, mode_d, pend_err_q, pend_err_d, pend_remap_q, pend_remap_d;
  logic [78:0] map_q, map_d;
  logic [8:0]  s2_q, s2_d;
  logic        remap_q, remap_d, err_q, err_d;
  logic [6:0]  scan_ch;
`else
  logic        unused_afh;
  assign unused_afh = ^{Fprime, regi_AFH_mode, regi_AFH_N, regi_AFH_map};
`endif

  always_comb begin
    state_d   = state_q;
    x_d = x_q;  a_d = a_q;  b_d = b_q;  y2_d = y2_q;
    e_d = e_q;  f_d = f_q;  p_d = p_q;  z_d = z_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    rf_chan_d = rf_chan_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    zsum      = x_q + a_q;
`ifdef HOPKERNEL_AFH_EN
    fp_d = fp_q;  n_d = n_q;  used_d = used_q;  found_d = found_q;
    mode_d = mode_q;  map_d = map_q;  s2_d = s2_q;
    pend_err_d = pend_err_q;  pend_remap_d = pend_remap_q;
    remap_d = remap_q;
    err_d   = 1'b0;
    scan_ch = idx_to_chan(cnt_q);
`endif
    case (state_q)
      S_IDLE: begin
        if (hop_start_p) begin
          x_d = X;  a_d = A;  b_d = B;  y2_d = Y2;  e_d = E;  f_d = F;
          p_d = {D, C ^ {5{Y1}}};
`ifdef HOPKERNEL_AFH_EN
          fp_d = Fprime;  mode_d = regi_AFH_mode;  n_d = regi_AFH_N;
          map_d = regi_AFH_map;  pend_err_d = 1'b0;  pend_remap_d = 1'b0;
`endif
          busy_d  = 1'b1;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        z_d     = {zsum[4], zsum[3:0] ^ b_q};
        cnt_d   = 7'd0;
        state_d = S_PERM;
      end
      S_PERM: begin
        z_d   = perm_stage(z_q, cnt_q[2:0], p_q[13], p_q[12]);
        p_d   = p_q << 2;
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd6) state_d = S_SUM;
      end
      S_SUM: begin
        s_d = {4'd0, z_q} + {2'd0, e_q} + {2'd0, f_q} + {3'd0, y2_q};
`ifdef HOPKERNEL_AFH_EN
        s2_d = {4'd0, z_q} + {2'd0, e_q} + {2'd0, fp_q} + {3'd0, y2_q};
`endif
        cnt_d   = 7'd0;
        state_d = S_MOD;
      end
      S_MOD: begin
        // Max sum 268 < 4*79, so three conditional subtracts finish the job.
        if (s_q >= 9'd79) s_d = s_q - 9'd79;
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd2) begin
          state_d = S_MAP;
`ifdef HOPKERNEL_AFH_EN
          if (mode_q) state_d = S_CHK;
`endif
        end
      end
`ifdef HOPKERNEL_AFH_EN
      S_CHK: begin
        if (map_q[idx_to_chan(s_q[6:0])]) begin
          state_d = S_MAP;
        end else if (n_q < 7'd20 || n_q > 7'd79) begin
          pend_err_d = 1'b1;
          state_d    = S_MAP;
        end else begin
          state_d = S_MODN;
        end
      end
      S_MODN: begin
        if (s2_q >= {2'd0, n_q}) begin
          s2_d = s2_q - {2'd0, n_q};
        end else begin
          cnt_d   = 7'd0;
          used_d  = 7'd0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // s2_q < N <= 79 here, so its low 7 bits are k'.
        if (map_q[scan_ch] && used_q == s2_q[6:0]) begin
          found_d      = scan_ch;
          pend_remap_d = 1'b1;
          state_d      = S_MAP;
        end else if (cnt_q == 7'd78) begin
          pend_err_d = 1'b1;
          state_d    = S_MAP;
        end else begin
          if (map_q[scan_ch]) used_d = used_q + 7'd1;
          cnt_d = cnt_q + 7'd1;
        end
      end
`endif
      S_MAP: begin
`ifdef HOPKERNEL_AFH_EN
        if (pend_err_q) begin
          err_d = 1'b1;
        end else if (pend_remap_q) begin
          rf_chan_d = found_q;
          remap_d   = 1'b1;
        end else begin
          rf_chan_d = idx_to_chan(s_q[6:0]);
          remap_d   = 1'b0;
        end
`else
        rf_chan_d = idx_to_chan(s_q[6:0]);
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_q <= S_IDLE;
      x_q <= '0;  a_q <= '0;  b_q <= '0;  y2_q <= '0;
      e_q <= '0;  f_q <= '0;  p_q <= '0;  z_q  <= '0;
      s_q <= '0;  cnt_q <= '0;
      rf_chan_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef HOPKERNEL_AFH_EN
      fp_q <= '0;  n_q <= '0;  used_q <= '0;  found_q <= '0;
      mode_q <= 1'b0;  map_q <= '0;  s2_q <= '0;
      pend_err_q <= 1'b0;  pend_remap_q <= 1'b0;
      remap_q <= 1'b0;  err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q <= x_d;  a_q <= a_d;  b_q <= b_d;  y2_q <= y2_d;
      e_q <= e_d;  f_q <= f_d;  p_q <= p_d;  z_q  <= z_d;
      s_q <= s_d;  cnt_q <= cnt_d;
      rf_chan_q <= rf_chan_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef HOPKERNEL_AFH_EN
      fp_q <= fp_d;  n_q <= n_d;  used_q <= used_d;  found_q <= found_d;
      mode_q <= mode_d;  map_q <= map_d;  s2_q <= s2_d;
      pend_err_q <= pend_err_d;  pend_remap_q <= pend_remap_d;
      remap_q <= remap_d;  err_q <= err_d;
`endif
    end
  end

  assign rf_chan    = rf_chan_q;
  assign hop_busy   = busy_q;
  assign hop_done_p = done_q;
`ifdef HOPKERNEL_AFH_EN
  assign chan_remapped = remap_q;
  assign hop_err       = err_q;
`else
  assign chan_remapped = 1'b0;
  assign hop_err       = 1'b0;
`endif

endmodule
